// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction sequencer: instruction fields, opcodes, FSM states.
// Pure declarations, no logic.
package cpu_pkg;

    localparam int INSTR_W  = 12;
    localparam int OPC_W    = 4;
    localparam int OPC_LSB  = 8;
    localparam int IMM_W    = 8;
    localparam int IMM_LSB  = 0;
    localparam int ALU_OP_W = 3;

    localparam logic [OPC_W-1:0] OP_JMP  = 4'h8;
    localparam logic [OPC_W-1:0] OP_JC   = 4'h9;
    localparam logic [OPC_W-1:0] OP_JNC  = 4'hA;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        HALT
    } state_t;

    // Opcodes with the top bit clear are passed straight to the operation block.
    function automatic logic is_alu(input logic [OPC_W-1:0] opc);
        return ~opc[OPC_W-1];
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Program-memory and operation-block signals of the sequencer.
// master = control_unit side, slave = memory / operation block side.
interface control_unit_if #(
    parameter int PC_WIDTH   = 8,
    parameter int DATA_WIDTH = 8
);
    import cpu_pkg::*;

    logic [PC_WIDTH-1:0]   instr_addr;
    logic [INSTR_W-1:0]    instr_data;
    logic                  carry_in;
    logic [ALU_OP_W-1:0]   operation_code;
    logic [DATA_WIDTH-1:0] in_b;
    logic                  aku_enable;

    modport master (
        output instr_addr, operation_code, in_b, aku_enable,
        input  instr_data, carry_in
    );

    modport slave (
        input  instr_addr, operation_code, in_b, aku_enable,
        output instr_data, carry_in
    );

endinterface

// File: rtl/pc_counter.sv
// Program counter register, priority clr > load > inc, wraps modulo 2^PC_WIDTH.
// Latency: 1 cycle from control to pc; no backpressure.
module pc_counter #(
    parameter int PC_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                load,
    input  logic [PC_WIDTH-1:0] load_val,
    input  logic                inc,
    output logic [PC_WIDTH-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    pc <= '0;
        else if (clr)  pc <= '0;
        else if (load) pc <= load_val;
        else if (inc)  pc <= pc + PC_WIDTH'(1);
    end

endmodule

// File: rtl/control_unit.sv
// Instruction sequencer: fetch/decode/exec of 12-bit instructions feeding operation_block.
// Latency: 3 cycles per instruction; no backpressure, start is ignored while busy.
module control_unit
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH   = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic           busy,
    output logic           halted,
    control_unit_if.master bus
);

    state_t                state, state_nxt;
    logic [INSTR_W-1:0]    ir;
    logic                  c_reg;
    logic [PC_WIDTH-1:0]   pc;
    logic                  pc_clr, pc_load, pc_inc;
    logic                  aku;
    logic [ALU_OP_W-1:0]   op_code_q;
    logic [DATA_WIDTH-1:0] in_b_q;

    logic [OPC_W-1:0] ir_opc, dec_opc;
    logic [IMM_W-1:0] ir_imm, dec_imm;

    assign ir_opc  = ir[OPC_LSB +: OPC_W];
    assign ir_imm  = ir[IMM_LSB +: IMM_W];
    assign dec_opc = bus.instr_data[OPC_LSB +: OPC_W];
    assign dec_imm = bus.instr_data[IMM_LSB +: IMM_W];

    pc_counter #(.PC_WIDTH(PC_WIDTH)) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (pc_clr),
        .load     (pc_load),
        .load_val (PC_WIDTH'(ir_imm)),
        .inc      (pc_inc),
        .pc       (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        halted    = 1'b0;
        aku       = 1'b0;
        pc_clr    = 1'b0;
        pc_load   = 1'b0;
        pc_inc    = 1'b0;
        case (state)
            IDLE:   if (start) state_nxt = FETCH;
            FETCH:  begin busy = 1'b1; state_nxt = DECODE; end
            DECODE: begin busy = 1'b1; state_nxt = EXEC; end
            EXEC: begin
                busy      = 1'b1;
                state_nxt = FETCH;
                if (is_alu(ir_opc)) begin
                    aku    = 1'b1;
                    pc_inc = 1'b1;
                end else begin
                    case (ir_opc)
                        OP_JMP:  pc_load = 1'b1;
                        OP_JC:   begin pc_load = c_reg;  pc_inc = ~c_reg; end
                        OP_JNC:  begin pc_load = ~c_reg; pc_inc = c_reg;  end
                        OP_HALT: state_nxt = HALT;
                        default: pc_inc = 1'b1;
                    endcase
                end
            end
            HALT: begin
                halted = 1'b1;
                if (start) begin
                    pc_clr    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand registers load at the end of DECODE so they are valid for the whole EXEC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir        <= '0;
            c_reg     <= 1'b0;
            op_code_q <= '0;
            in_b_q    <= '0;
        end else begin
            if (state == DECODE) begin
                ir <= bus.instr_data;
                if (is_alu(dec_opc)) begin
                    op_code_q <= dec_opc[ALU_OP_W-1:0];
                    in_b_q    <= DATA_WIDTH'(dec_imm);
                end
            end
            if (state == EXEC && is_alu(ir_opc)) c_reg <= bus.carry_in;
            else if (state == HALT && start)     c_reg <= 1'b0;
        end
    end

    assign bus.instr_addr     = pc;
    assign bus.operation_code = op_code_q;
    assign bus.in_b           = in_b_q;
    assign bus.aku_enable     = aku;

endmodule
